// File: rtl/spdif_sample_packer.sv
// Packs decoded S/PDIF subframes into 32-bit status-tagged words and queues them for the USB bridge.
// Optional build macro SPDIF_PACKER_PARITY_DROP_EN discards parity-errored subframes before the FIFO.
module spdif_sample_packer #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          capture_en,
  input  logic          sub_lock,
  input  logic          sub_valid,
  input  logic [23:0]   sub_data,
  input  logic          sub_chan,
  input  logic          sub_blk,
  input  logic          sub_v,
  input  logic          sub_u,
  input  logic          sub_c,
  input  logic          sub_perr,
  output logic [31:0]   tx,
  output logic          tx_en,
  input  logic          tx_ce,
  output logic [AW:0]   fill,
  output logic [15:0]   drop_count,
  output logic          overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [AW:0]   FILL_ZERO_C = {(AW+1){1'b0}};
  localparam logic [AW:0]   FILL_ONE_C  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   FILL_FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE_C   = {{(AW-1){1'b0}}, 1'b1};

  function automatic logic [31:0] pack_word(
    input logic        chan,
    input logic        blk,
    input logic        v,
    input logic        u,
    input logic        c,
    input logic        perr,
    input logic        gap,
    input logic        alt,
    input logic [23:0] data
  );
    return {chan, blk, v, u, c, perr, gap, alt, data};
  endfunction

  state_t        state_r, state_s;
  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   fill_r, fill_s;
  logic [31:0]   tx_r, head_s, word_s;
  logic          tx_en_r;
  logic [15:0]   drop_count_r;
  logic          overflow_r, gap_r, last_chan_r;
  logic          perr_ok_s, perr_bit_s, sync_hit_s;
  logic          cand_s, clr_s, first_s;
  logic          pop_s, push_s, drop_s, full_s, alt_s;

`ifdef SPDIF_PACKER_PARITY_DROP_EN
  assign perr_ok_s  = !sub_perr;
  assign perr_bit_s = 1'b0;
`else
  assign perr_ok_s  = 1'b1;
  assign perr_bit_s = sub_perr;
`endif

  assign sync_hit_s = sub_valid && sub_lock && sub_blk && !sub_chan && perr_ok_s;

  // Capture state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; disable wins over lock loss
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_en) state_s = ST_SYNC;
        else            state_s = ST_IDLE;
      end
      ST_SYNC: begin
        if (!capture_en)     state_s = ST_IDLE;
        else if (sync_hit_s) state_s = ST_RUN;
        else                 state_s = ST_SYNC;
      end
      ST_RUN: begin
        if (!capture_en)   state_s = ST_IDLE;
        else if (!sub_lock) state_s = ST_SYNC;
        else               state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State-decoded controls: write candidate, enable-time clear, alignment word marker
  always_comb begin
    cand_s  = 1'b0;
    clr_s   = 1'b0;
    first_s = 1'b0;
    case (state_r)
      ST_IDLE: clr_s = capture_en;
      ST_SYNC: begin
        cand_s  = capture_en && sync_hit_s;
        first_s = 1'b1;
      end
      ST_RUN:  cand_s = sub_valid && perr_ok_s;
      default: begin
        cand_s  = 1'b0;
        clr_s   = 1'b0;
        first_s = 1'b0;
      end
    endcase
  end

  assign pop_s  = (fill_r != FILL_ZERO_C) && tx_ce;
  assign full_s = (fill_r == FILL_FULL_C);
  assign push_s = cand_s && (!full_s || pop_s);
  assign drop_s = cand_s && !push_s;
  assign alt_s  = !first_s && (sub_chan == last_chan_r);
  assign word_s = pack_word(sub_chan, sub_blk, sub_v, sub_u, sub_c, perr_bit_s,
                            gap_r, alt_s, sub_data);

  // Occupancy after this edge's push/pop
  always_comb begin
    if (push_s && !pop_s)      fill_s = fill_r + FILL_ONE_C;
    else if (pop_s && !push_s) fill_s = fill_r - FILL_ONE_C;
    else                       fill_s = fill_r;
  end

  // Head word after this edge; a word pushed into an emptying FIFO bypasses the array
  always_comb begin
    head_s = tx_r;
    if (pop_s) begin
      if (fill_r == FILL_ONE_C) begin
        if (push_s) head_s = word_s;
        else        head_s = tx_r;
      end else begin
        head_s = mem_r[rd_ptr_r + PTR_ONE_C];
      end
    end else begin
      if (fill_r == FILL_ZERO_C && push_s) head_s = word_s;
      else                                 head_s = tx_r;
    end
  end

  // Word storage
  always_ff @(posedge clock) begin
    if (push_s) mem_r[wr_ptr_r] <= word_s;
  end

  // FIFO pointers, occupancy and registered head
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      fill_r   <= FILL_ZERO_C;
      tx_r     <= 32'h0000_0000;
      tx_en_r  <= 1'b0;
    end else begin
      fill_r  <= fill_s;
      tx_r    <= head_s;
      tx_en_r <= (fill_s != FILL_ZERO_C);
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
    end
  end

  // Overflow accounting, gap marker and last written channel
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_r <= 16'h0000;
      overflow_r   <= 1'b0;
      gap_r        <= 1'b0;
      last_chan_r  <= 1'b0;
    end else if (clr_s) begin
      drop_count_r <= 16'h0000;
      overflow_r   <= 1'b0;
      gap_r        <= 1'b0;
      last_chan_r  <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      gap_r      <= 1'b1;
      if (drop_count_r != 16'hFFFF) drop_count_r <= drop_count_r + 16'h0001;
    end else if (push_s) begin
      gap_r       <= 1'b0;
      last_chan_r <= sub_chan;
    end
  end

  assign tx         = tx_r;
  assign tx_en      = tx_en_r;
  assign fill       = fill_r;
  assign drop_count = drop_count_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_spdif_sample_packer.sv
// Directed scoreboard bench for spdif_sample_packer (DEPTH=16); honours SPDIF_PACKER_PARITY_DROP_EN.
module tb_spdif_sample_packer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        capture_en, sub_lock, sub_valid;
  logic [23:0] sub_data;
  logic        sub_chan, sub_blk, sub_v, sub_u, sub_c, sub_perr;
  logic [31:0] tx;
  logic        tx_en, tx_ce;
  logic [4:0]  fill;
  logic [15:0] drop_count;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] sb [$];

  spdif_sample_packer #(.DEPTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .capture_en(capture_en), .sub_lock(sub_lock),
    .sub_valid(sub_valid), .sub_data(sub_data), .sub_chan(sub_chan), .sub_blk(sub_blk),
    .sub_v(sub_v), .sub_u(sub_u), .sub_c(sub_c), .sub_perr(sub_perr),
    .tx(tx), .tx_en(tx_en), .tx_ce(tx_ce), .fill(fill),
    .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic chan, input logic blk, input logic [2:0] vuc,
                                     input logic perr, input logic gap, input logic alt,
                                     input logic [23:0] data);
    return {chan, blk, vuc, perr, gap, alt, data};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic chan, input logic blk, input logic [23:0] data,
                      input logic [2:0] vuc, input logic perr, input bit exp_wr,
                      input logic gap, input logic alt);
    sub_chan  = chan;
    sub_blk   = blk;
    sub_data  = data;
    {sub_v, sub_u, sub_c} = vuc;
    sub_perr  = perr;
    sub_valid = 1'b1;
    if (exp_wr) sb.push_back(mk(chan, blk, vuc, perr, gap, alt, data));
    tick();
    sub_valid = 1'b0;
    sub_perr  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (fill !== 5'd0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_drain_done"}, 32'(n < 200), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: a word presented with tx_ce high transfers on the coming edge
  always @(negedge clock) begin
    if (reset_n === 1'b1 && tx_en === 1'b1 && tx_ce === 1'b1) begin
      if (sb.size() == 0) begin
        check("tx_unexpected_word", 32'(sb.size()), 32'd1);
      end else begin
        check("tx_word", tx, sb.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0; capture_en = 1'b0; sub_lock = 1'b0; sub_valid = 1'b0;
    sub_data = 24'h000000; sub_chan = 1'b0; sub_blk = 1'b0;
    sub_v = 1'b0; sub_u = 1'b0; sub_c = 1'b0; sub_perr = 1'b0; tx_ce = 1'b0;
    repeat (3) tick();
    check("rst_tx", tx, 32'h0);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    tick();

    // Block alignment: only the A-channel block start opens the stream
    capture_en = 1'b1; sub_lock = 1'b1;
    tick();
    send(1'b1, 1'b1, 24'h111111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 24'h222222, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("align_skip_fill", 32'(fill), 32'd0);
    send(1'b0, 1'b1, 24'h123456, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("align_tx", tx, 32'h40123456);
    check("align_tx_en", 32'(tx_en), 32'd1);
    check("align_fill", 32'(fill), 32'd1);
    tx_ce = 1'b1;
    wait_drain("align");

    // Alternation with live draining (push into empty while tx_ce is high)
    send(1'b1, 1'b0, 24'hABCDEF, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 24'h000001, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 24'hFFFFFF, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 24'h800000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain("alt");
    tx_ce = 1'b0;

    // Overflow: 20 subframes into a stalled 16-deep FIFO
    for (int i = 0; i < 20; i++) begin
      logic [31:0] iv;
      iv = 32'(i);
      send(iv[0], 1'b0, 24'h100000 + iv[23:0], 3'b000, 1'b0, (i < 16), 1'b0, 1'b0);
    end
    check("ovf_fill", 32'(fill), 32'd16);
    check("ovf_drop", 32'(drop_count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head", tx, 32'h00100000);
    // Full with simultaneous pop: written, carries the gap flag
    tx_ce = 1'b1;
    send(1'b0, 1'b0, 24'h100014, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0);
    check("fullpop_fill", 32'(fill), 32'd16);
    check("fullpop_drop", 32'(drop_count), 32'd4);
    wait_drain("ovf");
    tx_ce = 1'b0;

    // Lock loss: re-sync, non-aligned subframes ignored
    sub_lock = 1'b0;
    tick();
    sub_lock = 1'b1;
    send(1'b0, 1'b0, 24'h300001, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b1, 1'b1, 24'h300002, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resync_skip_fill", 32'(fill), 32'd0);
    send(1'b0, 1'b1, 24'h200000, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 24'h200001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 24'h200002, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b0, 24'h200003, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 24'h200004, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("resync_fill", 32'(fill), 32'd5);

    // Disable: queued words still drain, stats survive until re-enable
    capture_en = 1'b0;
    tick();
    send(1'b1, 1'b0, 24'h3FFFFF, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle_fill", 32'(fill), 32'd5);
    tx_ce = 1'b1;
    wait_drain("disable");
    check("disable_tx_en", 32'(tx_en), 32'd0);
    check("disable_drop", 32'(drop_count), 32'd4);
    capture_en = 1'b1;
    tick();
    check("reen_drop", 32'(drop_count), 32'd0);
    check("reen_ovf", 32'(overflow), 32'd0);
    tx_ce = 1'b0;

    // Parity-errored subframe handling
    send(1'b0, 1'b1, 24'h0A0001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SPDIF_PACKER_PARITY_DROP_EN
    send(1'b1, 1'b0, 24'h0B0002, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 24'h0A0003, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1);
    check("perr_fill", 32'(fill), 32'd2);
`else
    send(1'b1, 1'b0, 24'h0B0002, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b0, 1'b0, 24'h0A0003, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("perr_fill", 32'(fill), 32'd3);
`endif
    check("perr_drop", 32'(drop_count), 32'd0);

    // Reset mid-drain clears the FIFO asynchronously
    tx_ce = 1'b1;
    tick();
    #1;
    reset_n = 1'b0;
    #1;
    check("arst_tx_en", 32'(tx_en), 32'd0);
    check("arst_fill", 32'(fill), 32'd0);
    sb.delete();
    tx_ce = 1'b0;
    capture_en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_fill", 32'(fill), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
